mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as the responder on the CPU's data-memory bus (addr / dataWrite / ramMode / read data). It decodes CPU loads and stores that fall in its address window, buffers written bytes in a FIFO and serialises them as 8N1 frames on txd. Read data is combinational because the CPU is single-cycle; all state changes occur on the rising clk edge.

---
 rtl/mmio_uart_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_uart_tx                                                 |
// | Description : Memory-mapped 8N1 UART transmitter sitting on the CPU data   |
// |               bus. Stores to TXDATA fill a byte FIFO that the serializer   |
// |               drains onto txd; STATUS and BAUDDIV are readable.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] dataWrite,
    input  logic [3:0]  sel,
    output logic [31:0] data,
    output logic        hit,
    output logic        txd,
    output logic        irq
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_REG_TXDATA  = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_BAUDDIV = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } txState_t;

    // Bus decode
    logic [31:0] w_offset;
    logic        w_inWindow;
    logic        w_isLoad;
    logic        w_isStore;
    logic [1:0]  w_regSel;
    logic        w_pushReq;
    logic        w_statusWr;
    logic        w_divWr;

    // FIFO
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    // Control/status
    logic        r_overflow;
    logic [15:0] r_div;
    logic [15:0] w_divEff;
    logic [15:0] w_baudLoad;
    logic [31:0] w_count32;
    logic [31:0] w_status;

    // Serializer
    txState_t    r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitCnt;
    logic [15:0] r_baudCnt;
    logic        r_txd;

    logic        w_unused;

    // Window check by offset so any BASE_ADDR works without aligned-compare tricks
    assign w_offset   = addr - BASE_ADDR;
    assign w_inWindow = (w_offset[31:4] == 28'd0);
    assign w_regSel   = w_offset[3:2];

    // Classify the ramMode code; unlisted codes are treated as idle
    always_comb begin
        w_isLoad  = 1'b0;
        w_isStore = 1'b0;
        case (sel)
            4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: w_isLoad  = 1'b1;
            4'b1000, 4'b1001, 4'b1010:                   w_isStore = 1'b1;
            default: begin
                w_isLoad  = 1'b0;
                w_isStore = 1'b0;
            end
        endcase
    end

    assign w_pushReq  = w_inWindow && w_isStore && (w_regSel == c_REG_TXDATA);
    assign w_statusWr = w_inWindow && w_isStore && (w_regSel == c_REG_STATUS);
    assign w_divWr    = w_inWindow && w_isStore && (w_regSel == c_REG_BAUDDIV);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts a byte when the serializer frees a slot this edge
    assign w_push  = w_pushReq && (!w_full || w_pop);

    assign w_divEff   = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_baudLoad = w_divEff - 16'd1;

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= dataWrite[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Sticky overflow flag, cleared by writing 1 to STATUS bit 3
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_pushReq && !w_push) begin
            r_overflow <= 1'b1;
        end else if (w_statusWr && dataWrite[3]) begin
            r_overflow <= 1'b0;
        end
    end

    // Baud divisor register; the serializer only samples it at bit boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DEFAULT_DIV;
        end else if (w_divWr) begin
            r_div <= dataWrite[15:0];
        end
    end

    // 8N1 serializer: each state lasts one baud period, data shifted out LSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'd0;
            r_bitCnt  <= 3'd0;
            r_baudCnt <= 16'd0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= r_mem[r_rdPtr];
                        r_state   <= S_START;
                        r_txd     <= 1'b0;
                        r_baudCnt <= w_baudLoad;
                    end
                end
                default: begin
                    if (r_baudCnt != 16'd0) begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end else begin
                        r_baudCnt <= w_baudLoad;
                        case (r_state)
                            S_START: begin
                                r_state  <= S_DATA;
                                r_txd    <= r_shift[0];
                                r_bitCnt <= 3'd0;
                            end
                            S_DATA: begin
                                if (r_bitCnt == 3'd7) begin
                                    r_state <= S_STOP;
                                    r_txd   <= 1'b1;
                                end else begin
                                    r_bitCnt <= r_bitCnt + 3'd1;
                                    r_shift  <= {1'b0, r_shift[7:1]};
                                    r_txd    <= r_shift[1];
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_txd   <= 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign w_count32 = 32'(r_count);
    assign w_status  = {20'd0, w_count32[3:0], 4'd0,
                        r_overflow, (r_state != S_IDLE), w_empty, w_full};

    // Combinational read mux for the single-cycle CPU; only load hits drive data
    always_comb begin
        data = 32'd0;
        if (w_inWindow && w_isLoad) begin
            case (w_regSel)
                c_REG_STATUS:  data = w_status;
                c_REG_BAUDDIV: data = {16'd0, r_div};
                default:       data = 32'd0;
            endcase
        end
    end

    assign hit = w_inWindow && (w_isLoad || w_isStore);
    assign txd = r_txd;
    assign irq = w_empty && (r_state == S_IDLE);

    assign w_unused = ^{w_offset[1:0], w_count32[31:4], dataWrite[31:16]};

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmio_uart_tx                                              |
// | Description : Self-checking bench for mmio_uart_tx: register table,        |
// |               directed frame/overflow/baud/reset sequences and random bus  |
// |               traffic against a frame-timeline reference model.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;

    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] LB     = 4'b0001;
    localparam logic [3:0] LW     = 4'b0011;
    localparam logic [3:0] LBU    = 4'b0100;
    localparam logic [3:0] LHU    = 4'b0101;
    localparam logic [3:0] SB     = 4'b1000;
    localparam logic [3:0] SW     = 4'b1010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] dataWrite = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] data;
    logic        hit;
    logic        txd;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .dataWrite(dataWrite),
        .sel      (sel),
        .data     (data),
        .hit      (hit),
        .txd      (txd),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue plus the timeline of the current frame
    logic [7:0]  mq[$];
    int          edgeN  = 0;
    int          fStart = -1000000;
    int          fDiv   = 1;
    logic [7:0]  fByte  = 8'd0;
    logic [15:0] mDiv   = 16'd4;
    logic        mOvf   = 1'b0;
    bit          autoChk = 1'b0;

    logic [7:0]  pat;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        expHit;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (edge %0d)", name, act, exp, edgeN);
        end
    endtask

    function automatic bit inWin(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'hF);
    endfunction

    function automatic bit isLoad(input logic [3:0] s);
        return s inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    endfunction

    function automatic bit isStore(input logic [3:0] s);
        return s inside {4'd8, 4'd9, 4'd10};
    endfunction

    function automatic int effDiv(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // True when the line is inside a frame after edge e
    function automatic bit inFrame(input int e);
        return (e >= fStart) && (e < fStart + 10 * fDiv);
    endfunction

    // Frame bit k = 0 start, 1..8 data LSB first, 9 stop
    function automatic logic mTxd(input int e);
        int k;
        if (!inFrame(e)) return 1'b1;
        k = (e - fStart) / fDiv;
        if (k == 0) return 1'b0;
        if (k <= 8) return fByte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] mStatus();
        logic [31:0] s;
        s       = 32'd0;
        s[0]    = (mq.size() == DEPTH);
        s[1]    = (mq.size() == 0);
        s[2]    = inFrame(edgeN);
        s[3]    = mOvf;
        s[11:8] = 4'(mq.size());
        return s;
    endfunction

    function automatic logic mHit(input logic [31:0] a, input logic [3:0] s);
        return inWin(a) && (isLoad(s) || isStore(s));
    endfunction

    function automatic logic [31:0] mRead(input logic [31:0] a, input logic [3:0] s);
        if (!(inWin(a) && isLoad(s))) return 32'd0;
        case (a[3:2])
            2'd1:    return mStatus();
            2'd2:    return {16'd0, mDiv};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs the DUT saw
    task automatic modelEdge();
        bit idleBefore;
        if (rst) begin
            mq.delete();
            fStart = -1000000;
            fDiv   = 1;
            mDiv   = 16'd4;
            mOvf   = 1'b0;
            return;
        end
        idleBefore = !inFrame(edgeN - 1);
        if (idleBefore && mq.size() > 0) begin
            fByte  = mq.pop_front();
            fStart = edgeN;
            fDiv   = effDiv(mDiv);
        end
        if (inWin(addr) && isStore(sel)) begin
            case (addr[3:2])
                2'd0: begin
                    if (mq.size() < DEPTH) mq.push_back(dataWrite[7:0]);
                    else mOvf = 1'b1;
                end
                2'd1: if (dataWrite[3]) mOvf = 1'b0;
                2'd2: mDiv = dataWrite[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        edgeN++;
        modelEdge();
        #1;
        if (autoChk) begin
            chk("txd_model", txd, mTxd(edgeN));
            chk("irq_model", irq, (mq.size() == 0) && !inFrame(edgeN));
        end
    endtask

    task automatic idle(input int n);
        sel = S_IDLE;
        repeat (n) step();
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        addr = a; sel = s; dataWrite = d;
        #1;
        if (autoChk) begin
            chk("hit_model", hit, mHit(a, s));
            chk("data_model", data, mRead(a, s));
        end
        step();
        sel = S_IDLE;
    endtask

    task automatic readChk(input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp,
                           input string name);
        addr = a; sel = s; dataWrite = 32'd0;
        #1;
        chk(name, data, exp);
        chk({name, "_hit"}, hit, 1);
        step();
        sel = S_IDLE;
    endtask

    task automatic expectBits(input logic b, input int n, input string name);
        repeat (n) begin
            step();
            chk(name, txd, b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{BASE + 32'h4,  LW,    32'd0,      1'b1, 32'h0000_0002};
        vecs[1]  = '{BASE + 32'h8,  LW,    32'd0,      1'b1, 32'h0000_0004};
        vecs[2]  = '{BASE + 32'h9,  LB,    32'd0,      1'b1, 32'h0000_0004};
        vecs[3]  = '{BASE + 32'h0,  LW,    32'd0,      1'b1, 32'h0000_0000};
        vecs[4]  = '{BASE + 32'hE,  LHU,   32'd0,      1'b1, 32'h0000_0000};
        vecs[5]  = '{BASE + 32'h20, LW,    32'd0,      1'b0, 32'h0000_0000};
        vecs[6]  = '{BASE - 32'h4,  LW,    32'd0,      1'b0, 32'h0000_0000};
        vecs[7]  = '{BASE + 32'h8,  4'b0110, 32'd0,    1'b0, 32'h0000_0000};
        vecs[8]  = '{BASE + 32'h8,  S_IDLE, 32'd0,     1'b0, 32'h0000_0000};
        vecs[9]  = '{BASE + 32'h4,  SW,    32'd0,      1'b1, 32'h0000_0000};
        vecs[10] = '{BASE + 32'hC,  SW,    32'hFFFF,   1'b1, 32'h0000_0000};
        vecs[11] = '{BASE + 32'h8,  LHU,   32'd0,      1'b1, 32'h0000_0004};
        vecs[12] = '{BASE + 32'h7,  LBU,   32'd0,      1'b1, 32'h0000_0002};

        // Reset
        autoChk = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("reset_txd", txd, 1);
        chk("reset_irq", irq, 1);
        rst = 1'b0;

        // Register table
        for (int i = 0; i < 13; i++) begin
            addr = vecs[i].a; sel = vecs[i].s; dataWrite = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_hit", i), hit, vecs[i].expHit);
            chk($sformatf("vec%0d_data", i), data, vecs[i].expData);
            step();
            sel = S_IDLE;
        end

        // Single frame 0xA5 at div 4
        pat = 8'hA5;
        access(BASE, SW, 32'h0000_00A5);
        for (int i = 1; i <= 40; i++) begin
            logic expBit;
            step();
            if (i <= 4) expBit = 1'b0;
            else if (i <= 36) expBit = pat[(i - 5) / 4];
            else expBit = 1'b1;
            chk("a5_txd", txd, expBit);
        end
        chk("a5_irq_in_stop", irq, 0);
        step();
        chk("a5_irq_done", irq, 1);

        // Fill, overflow, clear, push while full and popping
        for (int v = 1; v <= 9; v++) access(BASE, SB, 32'(v));
        readChk(BASE + 32'h4, LW, 32'h0000_0805, "full_status");
        access(BASE, SB, 32'h0000_000A);
        readChk(BASE + 32'h4, LW, 32'h0000_080D, "ovf_status");
        access(BASE + 32'h4, SW, 32'h0000_0008);
        readChk(BASE + 32'h4, LW, 32'h0000_0805, "ovf_clear");
        begin
            int target;
            target = fStart + 10 * fDiv + 1;
            for (int i = 0; i < 200 && edgeN < target - 1; i++) step();
            access(BASE, SB, 32'h0000_0077);
            readChk(BASE + 32'h4, LW, 32'h0000_0805, "popfull_status");
        end
        for (int i = 0; i < 2000 && irq !== 1'b1; i++) step();
        chk("drain_irq", irq, 1);

        // BAUDDIV change in the middle of data bit 3
        autoChk = 1'b0;
        pat = 8'h5A;
        access(BASE, SB, 32'h0000_005A);
        expectBits(1'b0, 4, "bd_start");
        for (int b = 0; b < 3; b++) expectBits(pat[b], 4, "bd_bit_old");
        expectBits(pat[3], 1, "bd_bit3");
        addr = BASE + 32'h8; sel = SW; dataWrite = 32'd2;
        expectBits(pat[3], 1, "bd_bit3");
        sel = S_IDLE;
        expectBits(pat[3], 2, "bd_bit3");
        for (int b = 4; b < 8; b++) expectBits(pat[b], 2, "bd_bit_new");
        expectBits(1'b1, 2, "bd_stop");
        step();
        chk("bd_irq", irq, 1);

        // BAUDDIV 0 gives one cycle per bit
        access(BASE + 32'h8, SW, 32'd0);
        readChk(BASE + 32'h8, LW, 32'd0, "bd_zero_read");
        pat = 8'hC3;
        access(BASE, SB, 32'h0000_00C3);
        expectBits(1'b0, 1, "b0_start");
        for (int b = 0; b < 8; b++) expectBits(pat[b], 1, "b0_bit");
        expectBits(1'b1, 1, "b0_stop");
        step();
        chk("b0_irq", irq, 1);

        // Resynchronise with a reset
        autoChk = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        readChk(BASE + 32'h8, LW, 32'd4, "rst_div");

        // Reset in the middle of data bit 5 with bytes still queued
        access(BASE, SB, 32'h0000_00FF);
        access(BASE, SB, 32'h0000_0011);
        access(BASE, SB, 32'h0000_0022);
        idle(23);
        chk("pre_rst_bit5", txd, 1);
        chk("pre_rst_busy", irq, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_txd", txd, 1);
        chk("rst_mid_irq", irq, 1);
        readChk(BASE + 32'h4, LW, 32'h0000_0002, "rst_mid_status");
        idle(100);

        // Random bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                idle(1);
            end else if (r < 60) begin
                access(BASE + 32'($urandom_range(0, 3)), SB + 4'($urandom_range(0, 2)), $urandom);
            end else if (r < 75) begin
                access(BASE + 32'($urandom_range(0, 15)), LB + 4'($urandom_range(0, 4)), $urandom);
            end else if (r < 85) begin
                if ($urandom_range(0, 1) == 0)
                    access(BASE + 32'h10 + 32'($urandom_range(0, 1000)), 4'($urandom_range(0, 15)), $urandom);
                else
                    access(BASE - 32'h1 - 32'($urandom_range(0, 1000)), 4'($urandom_range(0, 15)), $urandom);
            end else if (r < 90) begin
                access(BASE + 32'h4 + 32'($urandom_range(0, 3)), SB + 4'($urandom_range(0, 2)), $urandom);
            end else if (r < 95) begin
                logic [3:0] code;
                code = 4'($urandom_range(0, 15));
                if (isLoad(code) || isStore(code)) code = 4'hF;
                access(BASE + 32'($urandom_range(0, 15)), code, $urandom);
            end else if (mq.size() == 0 && !inFrame(edgeN)) begin
                access(BASE + 32'h8, SB + 4'($urandom_range(0, 2)), 32'($urandom_range(0, 3)));
            end else begin
                idle(1);
            end
        end
        for (int i = 0; i < 5000 && irq !== 1'b1; i++) step();
        chk("final_drain_irq", irq, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
